// File: rtl/qeciphy_pkg.sv
// rtl/qeciphy_pkg.sv - shared QECIPHY types, constants and FAW detection.
package qeciphy_pkg;

  localparam logic [63:0] FAW_PATTERN   = 64'hF6F6_2828_A5C3_3C5A;
  localparam int          RX_FRAME_LEN  = 64;
  localparam int          RX_CRC_PERIOD = 7;

  typedef enum logic [1:0] {
    RX_ALIGN_DISABLED = 2'd0,
    RX_ALIGN_SEARCH   = 2'd1,
    RX_ALIGN_CHECK    = 2'd2,
    RX_ALIGN_LOCKED   = 2'd3
  } rx_align_state_t;

  function automatic logic is_faw(input logic [63:0] data);
    return data == FAW_PATTERN;
  endfunction

endpackage

// File: rtl/qeciphy_rx_frame_pos_counter.sv
// rtl/qeciphy_rx_frame_pos_counter.sv - beat position in frame plus CRC group phase.
module qeciphy_rx_frame_pos_counter #(
  parameter int FRAME_LEN  = 64,
  parameter int CRC_PERIOD = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic advance_i,
  output logic pos_zero_o,
  output logic crc_last_o
);

  localparam int POS_W = $clog2(FRAME_LEN);
  localparam int GRP_W = (CRC_PERIOD > 1) ? $clog2(CRC_PERIOD) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(CRC_PERIOD - 1);
  localparam logic [GRP_W-1:0] GRP_ONE  = (CRC_PERIOD > 1) ? GRP_W'(1) : '0;

  logic [POS_W-1:0] pos_q, pos_d;
  logic [GRP_W-1:0] grp_q, grp_d;

  // Load marks the beat after a search hit, so it lands on pos 1.
  // Group phase is forced to 0 at frame wrap because the FAW beat is not in any group.
  always_comb begin
    pos_d = pos_q;
    grp_d = grp_q;
    if (clear_i) begin
      pos_d = '0;
      grp_d = '0;
    end else if (load_i) begin
      pos_d = POS_W'(1);
      grp_d = GRP_ONE;
    end else if (advance_i) begin
      if (pos_q == POS_LAST) begin
        pos_d = '0;
        grp_d = '0;
      end else begin
        pos_d = pos_q + 1'b1;
        grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= '0;
      grp_q <= '0;
    end else begin
      pos_q <= pos_d;
      grp_q <= grp_d;
    end
  end

  assign pos_zero_o = (pos_q == '0);
  assign crc_last_o = (grp_q == '0) && (pos_q != '0);

endmodule

// File: rtl/qeciphy_rx_frame_aligner.sv
// rtl/qeciphy_rx_frame_aligner.sv - RX FAW search/confirm/flywheel aligner with loss-of-lock recovery.
module qeciphy_rx_frame_aligner
  import qeciphy_pkg::*;
#(
  parameter int FRAME_LEN    = RX_FRAME_LEN,
  parameter int CRC_PERIOD   = RX_CRC_PERIOD,
  parameter int LOCK_COUNT   = 7,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [63:0]          tdata_i,
  input  logic                 tvalid_i,
  input  logic                 err_clr_i,
  output logic [63:0]          tdata_o,
  output logic                 tvalid_o,
  output logic                 locked_o,
  output logic                 faw_boundary_o,
  output logic                 crc_boundary_o,
  output logic                 lock_lost_o,
  output logic [ERR_CNT_W-1:0] faw_err_cnt_o,
  output logic [1:0]           align_state_o
);

  localparam int CHK_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  if (FRAME_LEN < 2 || CRC_PERIOD < 1 || LOCK_COUNT < 1 || UNLOCK_COUNT < 1 ||
      ((FRAME_LEN - 1) % CRC_PERIOD) != 0) begin : g_bad_geometry
    $error("qeciphy_rx_frame_aligner: illegal frame geometry");
  end

  rx_align_state_t      state_q, state_d;
  logic [CHK_W-1:0]     check_cnt_q, check_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                 armed_q, armed_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [63:0]          tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d, locked_q, locked_d;
  logic                 faw_b_q, faw_b_d, crc_b_q, crc_b_d, lost_q, lost_d;

  logic pc_clear, pc_load, pc_advance, pos_zero, crc_last, faw_hit, err_inc, in_lock;

  qeciphy_rx_frame_pos_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CRC_PERIOD(CRC_PERIOD)
  ) u_pos (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (pc_clear),
    .load_i    (pc_load),
    .advance_i (pc_advance),
    .pos_zero_o(pos_zero),
    .crc_last_o(crc_last)
  );

  always_comb begin
    state_d     = state_q;
    check_cnt_d = check_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    armed_d     = armed_q;
    pc_clear    = 1'b0;
    pc_load     = 1'b0;
    pc_advance  = 1'b0;
    err_inc     = 1'b0;
    lost_d      = 1'b0;
    faw_hit     = is_faw(tdata_i);
    in_lock     = enable_i && (state_q == RX_ALIGN_LOCKED);

    if (!enable_i) begin
      state_d     = RX_ALIGN_DISABLED;
      check_cnt_d = '0;
      miss_cnt_d  = '0;
      armed_d     = 1'b0;
      pc_clear    = 1'b1;
    end else begin
      case (state_q)
        RX_ALIGN_DISABLED: state_d = RX_ALIGN_SEARCH;
        RX_ALIGN_SEARCH: begin
          if (tvalid_i && faw_hit) begin
            pc_load     = 1'b1;
            check_cnt_d = '0;
            state_d     = RX_ALIGN_CHECK;
          end else begin
            pc_advance = tvalid_i;
          end
        end
        RX_ALIGN_CHECK: begin
          pc_advance = tvalid_i;
          if (tvalid_i && pos_zero) begin
            if (!faw_hit) begin
              state_d = RX_ALIGN_SEARCH;
            end else if (check_cnt_q == CHK_W'(LOCK_COUNT - 1)) begin
              state_d    = RX_ALIGN_LOCKED;
              armed_d    = 1'b0;
              miss_cnt_d = '0;
            end else begin
              check_cnt_d = check_cnt_q + 1'b1;
            end
          end
        end
        RX_ALIGN_LOCKED: begin
          pc_advance = tvalid_i;
          if (tvalid_i && pos_zero) begin
            armed_d = 1'b1;
            if (faw_hit) begin
              miss_cnt_d = '0;
            end else begin
              err_inc = 1'b1;
              if (miss_cnt_q == MISS_W'(UNLOCK_COUNT - 1)) begin
                state_d    = RX_ALIGN_SEARCH;
                miss_cnt_d = '0;
                lost_d     = 1'b1;
              end else begin
                miss_cnt_d = miss_cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = RX_ALIGN_DISABLED;
      endcase
    end

    // Clear beats a coincident increment; the counter sticks at all-ones.
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    tdata_d  = tdata_i;
    tvalid_d = tvalid_i && enable_i;
    locked_d = in_lock;
    faw_b_d  = in_lock && tvalid_i && pos_zero;
    crc_b_d  = in_lock && tvalid_i && armed_q && crc_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_ALIGN_DISABLED;
      check_cnt_q <= '0;
      miss_cnt_q  <= '0;
      armed_q     <= 1'b0;
      err_cnt_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      locked_q    <= 1'b0;
      faw_b_q     <= 1'b0;
      crc_b_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      check_cnt_q <= check_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      armed_q     <= armed_d;
      err_cnt_q   <= err_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      locked_q    <= locked_d;
      faw_b_q     <= faw_b_d;
      crc_b_q     <= crc_b_d;
      lost_q      <= lost_d;
    end
  end

  assign tdata_o        = tdata_q;
  assign tvalid_o       = tvalid_q;
  assign locked_o       = locked_q;
  assign faw_boundary_o = faw_b_q;
  assign crc_boundary_o = crc_b_q;
  assign lock_lost_o    = lost_q;
  assign faw_err_cnt_o  = err_cnt_q;
  assign align_state_o  = state_q;

endmodule
